pipelined_instr_decoder: RTL

- Registered, handshaked successor to the combinational opcode decoder.
- Takes 16-bit instructions from fetch over valid/ready and emits one registered control bundle per instruction to execute.
- Sign-extends immediates to XLEN and detects load-use hazards, inserting a bubble when needed.
- Flags illegal opcodes with a saturating counter and halts on HALT until resumed.

---
 rtl/pipelined_instr_decoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_instr_decoder.sv
// Registered instruction decoder: valid/ready in, one control bundle out, load-use bubble and HALT hold.
// Latency 1 cycle accept->out_valid; in_ready drops on output backpressure, hazard, or HALTED.
module pipelined_instr_decoder #(
    parameter int XLEN      = 16,
    parameter int CNT_W     = 8,
    parameter int HAZARD_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       opcode_out,
    output logic [2:0]       rd,
    output logic [2:0]       rs,
    output logic [2:0]       rt,
    output logic [XLEN-1:0]  imm,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrc2,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegSrc,
    output logic [3:0]       ALUOp,
    output logic             bubble,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count,
    output logic             halted,
    input  logic             resume
);
    typedef struct packed {
        logic [3:0]      opcode;
        logic [2:0]      rd;
        logic [2:0]      rs;
        logic [2:0]      rt;
        logic [XLEN-1:0] imm;
        logic [5:0]      ctrl;    // RegWrite RegDst ALUSrc2 MemWrite MemToReg RegSrc
        logic [3:0]      alu_op;
        logic            bubble;
        logic            illegal;
    } bundle_t;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;
    typedef enum logic [1:0] {IMM7, NZIMM, OFF9} imm_sel_t;

    state_t           state_q, state_d;
    bundle_t          bundle_q, bundle_d, dec;
    logic             out_valid_q, out_valid_d;
    logic             trk_vld_q, trk_vld_d;
    logic [2:0]       trk_rd_q, trk_rd_d;
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    imm_sel_t         imm_sel;
    logic             uses_rs, uses_rt;
    logic             load_en, hazard, accept;
    logic signed [6:0] imm7_s;
    logic signed [5:0] nzimm_s;
    logic signed [8:0] off9_s;

    assign imm7_s  = instr[6:0];
    assign nzimm_s = instr[5:0];
    assign off9_s  = instr[8:0];

    always_comb begin
        dec         = '0;
        dec.opcode  = instr[15:12];
        dec.rd      = instr[11:9];
        dec.rs      = instr[8:6];
        dec.rt      = instr[5:3];
        imm_sel     = IMM7;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        case (instr[15:12])
            4'h0: dec.ctrl = 6'b111010;
            4'h1: dec.ctrl = 6'b001100;
            4'h2: begin dec.ctrl = 6'b110000; uses_rs = 1'b1; end
            4'h3: begin dec.ctrl = 6'b111001; imm_sel = NZIMM; uses_rs = 1'b1; end
            4'h4: begin dec.ctrl = 6'b110001; dec.alu_op = 4'd2; uses_rs = 1'b1; uses_rt = 1'b1; end
            4'h5: begin dec.ctrl = 6'b111001; dec.alu_op = 4'd2; uses_rs = 1'b1; end
            4'h6: begin dec.ctrl = 6'b110001; dec.alu_op = 4'd3; uses_rs = 1'b1; uses_rt = 1'b1; end
            4'h7: begin dec.ctrl = 6'b110001; dec.alu_op = 4'd8; uses_rs = 1'b1; uses_rt = 1'b1; end
            4'h8: begin dec.ctrl = 6'b111001; dec.alu_op = 4'd4; imm_sel = NZIMM; uses_rs = 1'b1; end
            4'h9: begin dec.ctrl = 6'b111001; dec.alu_op = 4'd5; imm_sel = NZIMM; uses_rs = 1'b1; end
            4'hA: begin dec.ctrl = 6'b001000; dec.alu_op = 4'd6; imm_sel = OFF9; end
            4'hB: begin dec.ctrl = 6'b001000; dec.alu_op = 4'd7; imm_sel = OFF9; end
            4'hC, 4'hD, 4'hE: dec.illegal = 1'b1;
            default: ;
        endcase
        case (imm_sel)
            NZIMM:   dec.imm = XLEN'(nzimm_s);
            OFF9:    dec.imm = XLEN'(off9_s);
            default: dec.imm = XLEN'(imm7_s);
        endcase
    end

    always_comb begin
        load_en  = !out_valid_q || out_ready;
        hazard   = (HAZARD_EN != 0) && in_valid && trk_vld_q &&
                   ((uses_rs && (instr[8:6] == trk_rd_q)) || (uses_rt && (instr[5:3] == trk_rd_q)));
        in_ready = (state_q == ST_RUN) && load_en && !hazard;
        accept   = in_valid && in_ready;

        state_d         = state_q;
        bundle_d        = bundle_q;
        out_valid_d     = out_valid_q;
        trk_vld_d       = trk_vld_q;
        trk_rd_d        = trk_rd_q;
        illegal_count_d = illegal_count_q;

        if (load_en) begin
            if (accept) begin
                out_valid_d = 1'b1;
                bundle_d    = dec;
                trk_vld_d   = (instr[15:12] == 4'h0);
                trk_rd_d    = instr[11:9];
            end else if (hazard && state_q == ST_RUN) begin
                // Bubble bundle is all-zero except its flag; loading it retires the tracked LD.
                out_valid_d     = 1'b1;
                bundle_d        = '0;
                bundle_d.bubble = 1'b1;
                trk_vld_d       = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (accept && dec.illegal && illegal_count_q != '1)
            illegal_count_d = illegal_count_q + 1'b1;

        case (state_q)
            ST_RUN:    if (accept && instr[15:12] == 4'hF) state_d = ST_HALTED;
            ST_HALTED: if (resume) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            bundle_q        <= '0;
            out_valid_q     <= 1'b0;
            trk_vld_q       <= 1'b0;
            trk_rd_q        <= '0;
            illegal_count_q <= '0;
        end else begin
            state_q         <= state_d;
            bundle_q        <= bundle_d;
            out_valid_q     <= out_valid_d;
            trk_vld_q       <= trk_vld_d;
            trk_rd_q        <= trk_rd_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign opcode_out    = bundle_q.opcode;
    assign rd            = bundle_q.rd;
    assign rs            = bundle_q.rs;
    assign rt            = bundle_q.rt;
    assign imm           = bundle_q.imm;
    assign {RegWrite, RegDst, ALUSrc2, MemWrite, MemToReg, RegSrc} = bundle_q.ctrl;
    assign ALUOp         = bundle_q.alu_op;
    assign bubble        = bundle_q.bubble;
    assign illegal       = bundle_q.illegal;
    assign illegal_count = illegal_count_q;
    assign halted        = (state_q == ST_HALTED);
endmodule
